// File: rtl/laser_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : laser_pkg
//  Description : Shared constants, point type and host state encoding for the
//                LASER point-set initiator and its coverage checker.
//  Revision    : 1.0 - initial release
// ============================================================================
package laser_pkg;

    localparam int NUM_PTS   = 40;
    localparam int COORD_W   = 4;
    localparam int RADIUS_SQ = 16;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } point_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LRST   = 3'd1,
        ST_SEND   = 3'd2,
        ST_RUN    = 3'd3,
        ST_SCORE  = 3'd4,
        ST_FINISH = 3'd5
    } host_state_e;

endpackage
`default_nettype wire

// File: rtl/laser_cover_check.sv
`default_nettype none
// ============================================================================
//  Module      : laser_cover_check
//  Description : Combinational test of whether one point lies within the
//                coverage radius of either of two circle centres.
//  Revision    : 1.0 - initial release
// ============================================================================
module laser_cover_check
    import laser_pkg::*;
(
    input  point_t i_pt,
    input  point_t i_c1,
    input  point_t i_c2,
    output logic   o_covered
);

    localparam logic [8:0] c_radius_sq = 9'(RADIUS_SQ);

    // Squared Euclidean distance. |a-b| squared equals the square of the
    // 5-bit signed difference, so the magnitude form avoids a signed multiply.
    function automatic logic [8:0] dist_sq(input point_t a, input point_t b);
        logic [3:0] adx;
        logic [3:0] ady;
        logic [7:0] sqx;
        logic [7:0] sqy;
        adx = (a.x >= b.x) ? (a.x - b.x) : (b.x - a.x);
        ady = (a.y >= b.y) ? (a.y - b.y) : (b.y - a.y);
        sqx = {4'd0, adx} * {4'd0, adx};
        sqy = {4'd0, ady} * {4'd0, ady};
        return {1'b0, sqx} + {1'b0, sqy};
    endfunction

    logic [8:0] w_d1;
    logic [8:0] w_d2;

    // A point covered by both centres still yields a single covered flag.
    always_comb begin
        w_d1      = dist_sq(i_pt, i_c1);
        w_d2      = dist_sq(i_pt, i_c2);
        o_covered = (w_d1 <= c_radius_sq) || (w_d2 <= c_radius_sq);
    end

endmodule
`default_nettype wire

// File: rtl/laser_host.sv
`default_nettype none
// ============================================================================
//  Module      : laser_host
//  Description : LASER point-set initiator. Buffers 40 points, resets the
//                core, streams the points, waits for DONE (with a cycle
//                budget), captures both centres and scores coverage.
//  Revision    : 1.0 - initial release
// ============================================================================
module laser_host
    import laser_pkg::*;
#(
    parameter int MAX_CYCLE = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_ld_en,
    input  logic [5:0] i_ld_addr,
    input  logic [3:0] i_ld_x,
    input  logic [3:0] i_ld_y,
    input  logic       i_start,
    output logic       o_laser_rst,
    output logic [3:0] o_x,
    output logic [3:0] o_y,
    input  logic       i_done,
    input  logic [3:0] i_c1x,
    input  logic [3:0] i_c1y,
    input  logic [3:0] i_c2x,
    input  logic [3:0] i_c2y,
    output logic [3:0] o_res_c1x,
    output logic [3:0] o_res_c1y,
    output logic [3:0] o_res_c2x,
    output logic [3:0] o_res_c2y,
    output logic [5:0] o_cover,
    output logic       o_busy,
    output logic       o_res_valid,
    output logic       o_timeout,
    output logic       o_proto_err
);

    localparam logic [22:0] c_max_cycle = 23'(MAX_CYCLE);
    localparam logic [5:0]  c_num_pts   = 6'(NUM_PTS);
    localparam logic [5:0]  c_last_idx  = 6'(NUM_PTS - 1);

    host_state_e r_state;
    logic [5:0]  r_idx;
    logic [22:0] r_cnt;
    point_t      r_buf [NUM_PTS];
    point_t      r_res_c1;
    point_t      r_res_c2;
    logic [5:0]  r_cover;
    logic [3:0]  r_x;
    logic [3:0]  r_y;
    logic        r_laser_rst;
    logic        r_busy;
    logic        r_res_valid;
    logic        r_timeout;
    logic        r_proto_err;

    logic        w_ld_ok;
    logic [5:0]  w_idx_inc;
    point_t      w_cur_pt;
    logic        w_covered;

    assign w_ld_ok   = (r_state == ST_IDLE) && i_ld_en && (i_ld_addr < c_num_pts);
    assign w_idx_inc = r_idx + 6'd1;
    assign w_cur_pt  = r_buf[r_idx];

    laser_cover_check u_cover (
        .i_pt      (w_cur_pt),
        .i_c1      (r_res_c1),
        .i_c2      (r_res_c2),
        .o_covered (w_covered)
    );

    // Point buffer: loadable only while idle, contents survive runs and reset.
    always_ff @(posedge clk) begin
        if (w_ld_ok) begin
            r_buf[i_ld_addr].x <= i_ld_x;
            r_buf[i_ld_addr].y <= i_ld_y;
        end
    end

    // Run sequencer: core reset, point stream, DONE/budget wait, scoring.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_res_c1    <= '0;
            r_res_c2    <= '0;
            r_cover     <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_laser_rst <= 1'b0;
            r_busy      <= 1'b0;
            r_res_valid <= 1'b0;
            r_timeout   <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // X/Y mirror buffer[0] whenever no stream is in progress.
                    if (w_ld_ok && (i_ld_addr == 6'd0)) begin
                        r_x <= i_ld_x;
                        r_y <= i_ld_y;
                    end
                    if (i_start) begin
                        r_state     <= ST_LRST;
                        r_idx       <= '0;
                        r_busy      <= 1'b1;
                        r_laser_rst <= 1'b1;
                        r_res_valid <= 1'b0;
                        r_timeout   <= 1'b0;
                        r_proto_err <= 1'b0;
                        r_cover     <= '0;
                    end
                end
                ST_LRST: begin
                    // r_idx doubles as the two-cycle core reset counter.
                    if (r_idx == 6'd1) begin
                        r_state     <= ST_SEND;
                        r_laser_rst <= 1'b0;
                        r_idx       <= '0;
                        r_x         <= r_buf[0].x;
                        r_y         <= r_buf[0].y;
                    end else begin
                        r_idx <= w_idx_inc;
                    end
                end
                ST_SEND: begin
                    if (i_done) begin
                        // Core finished before it had all points: no scoring.
                        r_proto_err <= 1'b1;
                        r_state     <= ST_FINISH;
                        r_x         <= r_buf[0].x;
                        r_y         <= r_buf[0].y;
                    end else if (r_idx == c_last_idx) begin
                        r_state <= ST_RUN;
                        r_cnt   <= '0;
                        r_x     <= r_buf[0].x;
                        r_y     <= r_buf[0].y;
                    end else begin
                        r_idx <= w_idx_inc;
                        r_x   <= r_buf[w_idx_inc].x;
                        r_y   <= r_buf[w_idx_inc].y;
                    end
                end
                ST_RUN: begin
                    // DONE takes priority over the budget on the same edge.
                    if (i_done || (r_cnt > c_max_cycle)) begin
                        r_res_c1.x <= i_c1x;
                        r_res_c1.y <= i_c1y;
                        r_res_c2.x <= i_c2x;
                        r_res_c2.y <= i_c2y;
                        r_timeout  <= ~i_done;
                        r_state    <= ST_SCORE;
                        r_idx      <= '0;
                    end else begin
                        r_cnt <= r_cnt + 23'd1;
                    end
                end
                ST_SCORE: begin
                    if (w_covered) begin
                        r_cover <= r_cover + 6'd1;
                    end
                    if (r_idx == c_last_idx) begin
                        r_state <= ST_FINISH;
                    end else begin
                        r_idx <= w_idx_inc;
                    end
                end
                ST_FINISH: begin
                    r_res_valid <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_laser_rst = r_laser_rst;
    assign o_x         = r_x;
    assign o_y         = r_y;
    assign o_res_c1x   = r_res_c1.x;
    assign o_res_c1y   = r_res_c1.y;
    assign o_res_c2x   = r_res_c2.x;
    assign o_res_c2y   = r_res_c2.y;
    assign o_cover     = r_cover;
    assign o_busy      = r_busy;
    assign o_res_valid = r_res_valid;
    assign o_timeout   = r_timeout;
    assign o_proto_err = r_proto_err;

endmodule
`default_nettype wire

// File: doc/laser_host.md
# laser_host

Synthesizable initiator for the LASER point-set protocol. It holds 40 target points, resets the LASER core, streams the points one per cycle, waits for DONE with a cycle budget, captures the two returned circle centres, and scores coverage (points within distance 4 of either centre). It sits beside the LASER core on the on-chip self-test path and replaces the simulation-only pattern driver for silicon bring-up.

## Interface
- MAX_CYCLE, 5000000: RUN-state cycle budget before a forced capture.
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- LD_EN  in  1  write one point into the buffer; ignored unless IDLE.
- LD_ADDR  in  6  point index; values 40..63 are ignored.
- LD_X, LD_Y  in  4 each  point coordinates.
- START  in  1  one-cycle pulse; begins a run from IDLE, ignored otherwise.
- LASER_RST  out  1  reset driven to the LASER core.
- X, Y  out  4 each  point stream to the core.
- DONE  in  1  core completion.
- C1X, C1Y, C2X, C2Y  in  4 each  core result centres.
- RES_C1X, RES_C1Y, RES_C2X, RES_C2Y  out  4 each  captured centres.
- COVER  out  6  covered point count, 0..40.
- BUSY  out  1  high in every state except IDLE.
- RES_VALID  out  1  high from FINISH until the next accepted START.
- TIMEOUT  out  1  capture was forced by the budget.
- PROTO_ERR  out  1  DONE was seen during SEND.

## Operation
- States: IDLE -> LRST (2 cycles) -> SEND (40 cycles) -> RUN -> SCORE (40 cycles) -> FINISH -> IDLE.
- IDLE: accepts LD_EN writes to a 40x8-bit buffer. The buffer keeps its contents across runs and is not cleared by a run.
- START in IDLE: clear RES_VALID, TIMEOUT, PROTO_ERR and COVER, then enter LRST.
- LRST: LASER_RST=1 for exactly 2 cycles. The point index resets to 0.
- SEND: LASER_RST=0. In cycle k (k=0..39), X/Y = buffer[k].
  - If DONE=1 in any SEND cycle: set PROTO_ERR, keep COVER=0, go to FINISH and skip SCORE.
- RUN: a 23-bit cycle counter starts at 0.
  - On DONE=1: latch C1X..C2Y into RES_*.
  - When the counter exceeds MAX_CYCLE: latch C1X..C2Y and set TIMEOUT.
  - Either case then goes to SCORE.
- SCORE: one point per cycle, index 0..39.
  - dx = RES_CnX - px as 5-bit signed, same for dy.
  - d = dx*dx + dy*dy, 9-bit unsigned, maximum 450.
  - The point is covered if d1 <= 16 or d2 <= 16, and then COVER increments. A point is counted once even when both centres cover it.
- FINISH: one cycle. RES_VALID=1, then IDLE.
- X/Y outside SEND hold buffer[0].

## Timing
- Reset values: LASER_RST=0, X=Y=0, all RES_*=0, COVER=0, BUSY=0, RES_VALID=0, TIMEOUT=0, PROTO_ERR=0. State is IDLE and the buffer is undefined.
- START sampled at edge t: BUSY=1 and LASER_RST=1 from t+1 through t+2. The first point is on X/Y at t+3, the last at t+42.
- DONE is registered-sampled. Capture uses C* values from the same edge on which DONE is seen high.
- SCORE takes 40 cycles. RES_VALID rises 41 cycles after the DONE edge, including the FINISH cycle.
- DONE and the timeout condition on the same edge: DONE wins and TIMEOUT stays 0.
- START and LD_EN in the same IDLE cycle: both are taken. The write completes before the run reads the buffer.
- RST asserted mid-run: all outputs return to reset values immediately and state goes to IDLE. LASER_RST drops to 0.

## Structure
- Package laser_pkg holds:
  - NUM_PTS=40, COORD_W=4, RADIUS_SQ=16.
  - Typedef point_t {x, y}.
  - host_state_e enum.
- Sub-module laser_cover_check: combinational. Inputs are one point and two centres; output is a 1-bit covered flag. It will be reused by the LASER core's scorer.
- The FSM, counters and buffer stay in laser_host.

## Test plan
- Load 40 points all at (8,8). START. Behavioural core returns DONE after 100 cycles with C1=(8,8), C2=(0,0) -> COVER=40, TIMEOUT=0, PROTO_ERR=0, RES_VALID after 100+41 cycles.
- Points at (0,0),(4,0),(5,0),(3,3),(0,4) with the rest at (15,15). Core returns C1=(0,0), C2=(15,15) -> d: 0,16,25,18,16 -> COVER=38.
- Core never raises DONE, MAX_CYCLE overridden to 50 -> capture at RUN cycle 51, TIMEOUT=1, COVER computed from the live C* values.
- Core raises DONE at SEND cycle 10 -> PROTO_ERR=1, COVER=0, RES_VALID=1 one cycle later, no SCORE cycles.
- Assert RST during SCORE -> BUSY=0 and RES_VALID=0 immediately. A following START completes a full run with the buffer reloaded.
- START pulsed while BUSY, and LD_EN pulsed while BUSY -> both ignored. The run result and buffer are unchanged (check LD_ADDR=40 is also ignored in IDLE).
